// File: rtl/axis_trailer_pkg.sv
// Shared types and helpers for the export-link trailer stage.
// Holds the FSM state encoding, the trailer field offsets and the saturating beat counter step.
package axis_trailer_pkg;

  typedef enum logic [0:0] {
    PASS    = 1'b0,
    TRAILER = 1'b1
  } trl_state_e;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_SEQ_WIDTH  = 32;
  localparam int DEF_CNT_WIDTH  = 32;

  // Trailer word layout for the default build: beat count in the low field, sequence above it.
  localparam int TRL_CNT_LSB = 0;
  localparam int TRL_SEQ_LSB = DEF_CNT_WIDTH;

  // Increment v, holding at the largest value representable in w bits.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/axis_export_trailer.sv
// AXI-Stream pass-through that moves TLAST onto one appended trailer beat carrying
// the frame sequence number and payload beat count; output is a single registered stage.
module axis_export_trailer
  import axis_trailer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SEQ_WIDTH  = DEF_SEQ_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_last,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_last,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [SEQ_WIDTH-1:0]  seq_no
);

  // The sequence field sits directly above the count field, whatever the count width is.
  localparam int SEQ_LSB = TRL_SEQ_LSB - DEF_CNT_WIDTH + CNT_WIDTH;

  if (DATA_WIDTH < SEQ_WIDTH + CNT_WIDTH) begin : g_width_chk
    $error("axis_export_trailer: DATA_WIDTH must be >= SEQ_WIDTH + CNT_WIDTH");
  end

  trl_state_e            state, state_nxt;
  logic [CNT_WIDTH-1:0]  beat_cnt, beat_cnt_nxt;
  logic [SEQ_WIDTH-1:0]  seq_no_nxt;
  logic [DATA_WIDTH-1:0] dout_data_nxt;
  logic                  dout_last_nxt;
  logic                  dout_valid_nxt;
  logic [DATA_WIDTH-1:0] trailer;
  logic                  load_ok;

  assign load_ok   = !dout_valid || dout_ready;
  assign din_ready = (state == PASS) && load_ok;

  always_comb begin
    trailer = '0;
    trailer[TRL_CNT_LSB +: CNT_WIDTH] = beat_cnt;
    trailer[SEQ_LSB +: SEQ_WIDTH]     = seq_no;
  end

  always_comb begin
    state_nxt      = state;
    beat_cnt_nxt   = beat_cnt;
    seq_no_nxt     = seq_no;
    dout_data_nxt  = dout_data;
    dout_last_nxt  = dout_last;
    dout_valid_nxt = dout_valid;
    // A completed handshake empties the stage unless something reloads it below.
    if (dout_valid && dout_ready) dout_valid_nxt = 1'b0;
    unique case (state)
      PASS: begin
        if (din_valid && din_ready) begin
          dout_data_nxt  = din_data;
          dout_last_nxt  = 1'b0;
          dout_valid_nxt = 1'b1;
          beat_cnt_nxt   = CNT_WIDTH'(sat_inc(64'(beat_cnt), CNT_WIDTH));
          if (din_last) state_nxt = TRAILER;
        end
      end
      TRAILER: begin
        if (load_ok) begin
          dout_data_nxt  = trailer;
          dout_last_nxt  = 1'b1;
          dout_valid_nxt = 1'b1;
          seq_no_nxt     = seq_no + SEQ_WIDTH'(1);
          beat_cnt_nxt   = '0;
          state_nxt      = PASS;
        end
      end
      default: state_nxt = PASS;
    endcase
  end

  // Output stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= PASS;
      beat_cnt   <= '0;
      seq_no     <= '0;
      dout_data  <= '0;
      dout_last  <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_cnt_nxt;
      seq_no     <= seq_no_nxt;
      dout_data  <= dout_data_nxt;
      dout_last  <= dout_last_nxt;
      dout_valid <= dout_valid_nxt;
    end
  end

endmodule

// File: tb/tb_axis_export_trailer.sv
// Scoreboard bench for axis_export_trailer: default 64/32/32 build plus a 16/4/4 build for
// counter saturation and sequence wrap.
module tb_axis_export_trailer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] din_data, dout_data;
  logic        din_last, din_valid, din_ready;
  logic        dout_last, dout_valid, dout_ready;
  logic [31:0] seq_no;

  logic [15:0] s_din_data, s_dout_data;
  logic        s_din_last, s_din_valid, s_din_ready;
  logic        s_dout_last, s_dout_valid, s_dout_ready;
  logic [3:0]  s_seq_no;

  axis_export_trailer #(.DATA_WIDTH(64), .SEQ_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_last(din_last), .din_valid(din_valid), .din_ready(din_ready),
    .dout_data(dout_data), .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .seq_no(seq_no)
  );

  axis_export_trailer #(.DATA_WIDTH(16), .SEQ_WIDTH(4), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst),
    .din_data(s_din_data), .din_last(s_din_last), .din_valid(s_din_valid), .din_ready(s_din_ready),
    .dout_data(s_dout_data), .dout_last(s_dout_last), .dout_valid(s_dout_valid), .dout_ready(s_dout_ready),
    .seq_no(s_seq_no)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rdy_mode = 0;
  int exp_seq  = 0;

  logic [64:0] exp_q[$];
  logic [16:0] exp_s[$];
  int          hs_cyc[$];

  always @(posedge clk) cyc++;

  // Output ready driver: 0 = always ready, 1 = random 50%, 2 = stalled.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = 1'($urandom_range(0, 1));
      default: dout_ready = 1'b0;
    endcase
  end

  function automatic logic [64:0] mk_trl(input int s, input int c);
    return {1'b1, 32'(s), 32'(c)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Main monitor: pops expectations on each handshake and checks hold under stall.
  logic        stall_prev = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_vec++;
        if (!dout_valid || dout_data !== prev_data || dout_last !== prev_last) begin
          n_bad++;
          $display("FAIL stall_hold got v=%0b last=%0b data=%h want v=1 last=%0b data=%h",
                   dout_valid, dout_last, dout_data, prev_last, prev_data);
        end
      end
      if (dout_valid && dout_ready) begin
        logic [64:0] e;
        n_vec++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL out_unexpected got last=%0b data=%h want none", dout_last, dout_data);
        end else begin
          e = exp_q.pop_front();
          if ({dout_last, dout_data} !== e) begin
            n_bad++;
            $display("FAIL out_beat got last=%0b data=%h want last=%0b data=%h",
                     dout_last, dout_data, e[64], e[63:0]);
          end
        end
      end
      stall_prev = dout_valid && !dout_ready;
      prev_data  = dout_data;
      prev_last  = dout_last;
    end
  end

  // Narrow-build monitor.
  always @(negedge clk) begin
    if (!rst && s_dout_valid && s_dout_ready) begin
      logic [16:0] e;
      n_vec++;
      if (exp_s.size() == 0) begin
        n_bad++;
        $display("FAIL s_out_unexpected got last=%0b data=%h want none", s_dout_last, s_dout_data);
      end else begin
        e = exp_s.pop_front();
        if ({s_dout_last, s_dout_data} !== e) begin
          n_bad++;
          $display("FAIL s_out_beat got last=%0b data=%h want last=%0b data=%h",
                   s_dout_last, s_dout_data, e[16], e[15:0]);
        end
      end
    end
  end

  // Called and returns just after a rising edge.
  task automatic send_beat(input bit sel, input logic [63:0] d, input bit l);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    if (!sel) begin din_data = d; din_last = l; din_valid = 1'b1; end
    else begin s_din_data = d[15:0]; s_din_last = l; s_din_valid = 1'b1; end
    while (!done && n < 1000) begin
      @(negedge clk);
      done = sel ? s_din_ready : din_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!sel) begin din_valid = 1'b0; din_last = 1'b0; end
    else begin s_din_valid = 1'b0; s_din_last = 1'b0; end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout got=not_accepted want=accepted");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_s.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0 || exp_s.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d/%0d pending want=0/0", exp_q.size(), exp_s.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    exp_seq = 0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nb;
    logic [63:0] d;
    rst = 1'b1;
    din_data = '0; din_last = 1'b0; din_valid = 1'b0;
    s_din_data = '0; s_din_last = 1'b0; s_din_valid = 1'b0; s_dout_ready = 1'b1;
    dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout_valid", 64'(dout_valid), 64'd0);
    check("rst_dout_data", dout_data, 64'd0);
    check("rst_dout_last", 64'(dout_last), 64'd0);
    check("rst_seq_no", 64'(seq_no), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("idle_din_ready", 64'(din_ready), 64'd1);

    // 1: three-beat frame
    exp_q.push_back({1'b0, 64'hAAAA_0000_0000_0001});
    exp_q.push_back({1'b0, 64'hBBBB_0000_0000_0002});
    exp_q.push_back({1'b0, 64'hCCCC_0000_0000_0003});
    exp_q.push_back({1'b1, 64'h00000000_00000003});
    send_beat(0, 64'hAAAA_0000_0000_0001, 0);
    send_beat(0, 64'hBBBB_0000_0000_0002, 0);
    send_beat(0, 64'hCCCC_0000_0000_0003, 1);
    drain();
    check("t1_seq_no", 64'(seq_no), 64'd1);

    // 2: back-to-back single-beat frames
    do_reset();
    base = hs_cyc.size();
    exp_q.push_back({1'b0, 64'h5858_5858_5858_5858});
    exp_q.push_back({1'b1, 64'h00000000_00000001});
    exp_q.push_back({1'b0, 64'h5959_5959_5959_5959});
    exp_q.push_back({1'b1, 64'h00000001_00000001});
    send_beat(0, 64'h5858_5858_5858_5858, 1);
    send_beat(0, 64'h5959_5959_5959_5959, 1);
    drain();
    check("t2_beats", 64'(hs_cyc.size() - base), 64'd4);
    if (hs_cyc.size() - base == 4)
      check("t2_span", 64'(hs_cyc[base+3] - hs_cyc[base]), 64'd3);
    check("t2_seq_no", 64'(seq_no), 64'd2);

    // 3: random backpressure over 100 frames
    do_reset();
    rdy_mode = 1;
    for (int f = 0; f < 100; f++) begin
      nb = $urandom_range(1, 17);
      for (int b = 0; b < nb; b++) begin
        d = {$urandom, $urandom};
        exp_q.push_back({1'b0, d});
        send_beat(0, d, b == nb - 1);
      end
      exp_q.push_back(mk_trl(exp_seq, nb));
      exp_seq++;
    end
    drain();
    rdy_mode = 0;
    check("t3_seq_no", 64'(seq_no), 64'd100);

    // 4: input held during a stalled trailer
    rdy_mode = 2;
    exp_q.push_back({1'b0, 64'h7777_0000_0000_0077});
    exp_q.push_back(mk_trl(exp_seq, 1));
    exp_q.push_back({1'b0, 64'h2222_0000_0000_0022});
    exp_q.push_back(mk_trl(exp_seq + 1, 1));
    exp_seq += 2;
    send_beat(0, 64'h7777_0000_0000_0077, 1);
    din_data = 64'h2222_0000_0000_0022; din_last = 1'b1; din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall_din_ready", 64'(din_ready), 64'd0);
    end
    rdy_mode = 0;
    @(posedge clk);
    @(negedge clk);
    check("t4_trailer_din_ready", 64'(din_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("t4_resume_din_ready", 64'(din_ready), 64'd1);
    @(posedge clk); #1;
    din_valid = 1'b0; din_last = 1'b0;
    drain();

    // 5: reset in the middle of a frame
    exp_q.push_back({1'b0, 64'h0000_0000_0000_00F1});
    send_beat(0, 64'h0000_0000_0000_00F1, 0);
    send_beat(0, 64'h0000_0000_0000_00F2, 0);
    rst = 1'b1;
    #1;
    check("t5_rst_dout_valid", 64'(dout_valid), 64'd0);
    check("t5_rst_seq_no", 64'(seq_no), 64'd0);
    check("t5_rst_dout_data", dout_data, 64'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    exp_seq = 0;
    check("t5_queue_after_rst", 64'(exp_q.size()), 64'd0);
    exp_q.push_back({1'b0, 64'h0000_0000_0000_00E1});
    exp_q.push_back({1'b1, 64'h00000000_00000001});
    send_beat(0, 64'h0000_0000_0000_00E1, 1);
    drain();

    // 6: narrow build, saturation and wrap
    for (int b = 0; b < 20; b++) begin
      exp_s.push_back({1'b0, 16'(16'hA000 + b)});
      send_beat(1, 64'(16'hA000 + b), b == 19);
    end
    exp_s.push_back({1'b1, 16'h000F});
    for (int f = 1; f <= 16; f++) begin
      exp_s.push_back({1'b0, 16'(16'hB000 + f)});
      exp_s.push_back({1'b1, 8'h00, 4'(f), 4'd1});
      send_beat(1, 64'(16'hB000 + f), 1);
    end
    drain();
    check("t6_s_seq_no", 64'(s_seq_no), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
